// File: rtl/engine_rpm_model.sv
// Engine rpm model: tick-paced crank/run/shift state machine producing an
// rpm value for the transmission stage, with idle floor and saturation.
module engine_rpm_model #(
  parameter int unsigned TICK_DIV    = 1000,
  parameter logic [31:0] ACCEL_STEP  = 32'h10,
  parameter logic [31:0] DRAG_STEP   = 32'h4,
  parameter logic [31:0] BRAKE_STEP  = 32'h40,
  parameter logic [31:0] CRANK_STEP  = 32'h20,
  parameter int unsigned CRANK_TICKS = 4,
  parameter logic [31:0] RPM_IDLE    = 32'h80,
  parameter logic [31:0] RPM_MAX     = 32'h00FFFFFF,
  parameter int unsigned HOLD_TICKS  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ignition,
  input  logic [3:0]  throttle,
  input  logic        brake,
  input  logic [7:0]  gearRatio,
  input  logic [1:0]  shift,
  output logic [31:0] rpmVal,
  output logic [1:0]  state,
  output logic        overrev
);

  typedef enum logic [1:0] {
    ST_STOPPED  = 2'b00,
    ST_CRANK    = 2'b01,
    ST_RUN      = 2'b10,
    ST_SHIFTING = 2'b11
  } state_t;

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [31:0] CRANK_LAST = 32'(CRANK_TICKS - 1);
  localparam logic [31:0] HOLD_LAST  = 32'(HOLD_TICKS - 1);

  state_t      st;
  logic [CW-1:0] tick_cnt;
  logic        tick;
  logic [1:0]  shift_q;
  logic        shift_evt;
  logic [31:0] crank_cnt;
  logic [31:0] hold_cnt;

  logic [47:0] accel_prod;
  logic [48:0] accel_sum;
  logic [32:0] crank_sum;
  logic [31:0] rpm_stop, rpm_crank, rpm_run, rpm_up, rpm_dn;

  assign tick      = (tick_cnt == TICK_LAST);
  assign shift_evt = (shift_q == 2'b00) && ((shift == 2'b01) || (shift == 2'b10));
  assign state     = st;
  assign overrev   = (rpmVal == RPM_MAX);

  // Candidate next-rpm values for every state/condition, all saturating.
  always_comb begin
    accel_prod = 48'(throttle) * 48'(gearRatio) * 48'(ACCEL_STEP);
    accel_sum  = {17'b0, rpmVal} + {1'b0, accel_prod};
    crank_sum  = {1'b0, rpmVal} + {1'b0, CRANK_STEP};

    rpm_stop  = (rpmVal >= DRAG_STEP) ? (rpmVal - DRAG_STEP) : '0;
    rpm_crank = (crank_sum >= {1'b0, RPM_MAX}) ? RPM_MAX : crank_sum[31:0];

    if (brake) begin
      rpm_run = ({1'b0, rpmVal} >= ({1'b0, RPM_IDLE} + {1'b0, BRAKE_STEP})) ?
                (rpmVal - BRAKE_STEP) : RPM_IDLE;
    end else if (throttle != 4'd0) begin
      rpm_run = (accel_sum >= {17'b0, RPM_MAX}) ? RPM_MAX : accel_sum[31:0];
    end else begin
      rpm_run = ({1'b0, rpmVal} >= ({1'b0, RPM_IDLE} + {1'b0, DRAG_STEP})) ?
                (rpmVal - DRAG_STEP) : RPM_IDLE;
    end

    rpm_up = ((rpmVal >> 1) > RPM_IDLE) ? (rpmVal >> 1) : RPM_IDLE;
    rpm_dn = ({rpmVal, 1'b0} >= {1'b0, RPM_MAX}) ? RPM_MAX : {rpmVal[30:0], 1'b0};
  end

  // Free-running tick divider and one-cycle shift history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      shift_q  <= 2'b00;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      shift_q  <= shift;
    end
  end

  // Main state machine; ignition-low outranks shift events, shifts outrank ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= ST_STOPPED;
      rpmVal    <= '0;
      crank_cnt <= '0;
      hold_cnt  <= '0;
    end else begin
      case (st)
        ST_STOPPED: begin
          if (tick) rpmVal <= rpm_stop;
          if (ignition) begin
            st        <= ST_CRANK;
            crank_cnt <= '0;
          end
        end
        ST_CRANK: begin
          if (!ignition) begin
            st <= ST_STOPPED;
          end else if (tick) begin
            if (crank_cnt == CRANK_LAST) begin
              rpmVal <= RPM_IDLE;
              st     <= ST_RUN;
            end else begin
              rpmVal    <= rpm_crank;
              crank_cnt <= crank_cnt + 32'd1;
            end
          end
        end
        ST_RUN: begin
          if (!ignition) begin
            st <= ST_STOPPED;
          end else if (shift_evt) begin
            rpmVal   <= (shift == 2'b01) ? rpm_up : rpm_dn;
            st       <= ST_SHIFTING;
            hold_cnt <= '0;
          end else if (tick) begin
            rpmVal <= rpm_run;
          end
        end
        ST_SHIFTING: begin
          if (!ignition) begin
            st <= ST_STOPPED;
          end else if (tick) begin
            if (hold_cnt == HOLD_LAST) st <= ST_RUN;
            else hold_cnt <= hold_cnt + 32'd1;
          end
        end
        default: st <= ST_STOPPED;
      endcase
    end
  end

endmodule

// File: tb/tb_engine_rpm_model.sv
// Directed bench for engine_rpm_model with TICK_DIV=4.
module tb_engine_rpm_model;

  logic        clk;
  logic        rst_n;
  logic        ignition;
  logic [3:0]  throttle;
  logic        brake;
  logic [7:0]  gearRatio;
  logic [1:0]  shift;
  logic [31:0] rpmVal;
  logic [1:0]  state;
  logic        overrev;

  int checks   = 0;
  int failures = 0;
  int edges    = 0;
  logic [31:0] exp_rpm;

  localparam logic [31:0] MAXV = 32'h00FFFFFF;

  engine_rpm_model #(.TICK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .ignition(ignition), .throttle(throttle),
    .brake(brake), .gearRatio(gearRatio), .shift(shift),
    .rpmVal(rpmVal), .state(state), .overrev(overrev)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising edges since reset release; ticks land on every 4th edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges = 0;
    else edges = edges + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_tick;
    do begin
      @(posedge clk);
      #1;
    end while (edges % 4 != 0);
  endtask

  initial begin
    rst_n = 1'b0; ignition = 1'b0; throttle = 4'd0; brake = 1'b0;
    gearRatio = 8'd0; shift = 2'b00;
    #12;
    chk("reset_rpm", rpmVal, 32'h0);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_overrev", 32'(overrev), 32'd0);

    // Crank sequence
    @(negedge clk);
    ignition = 1'b1; gearRatio = 8'd4; rst_n = 1'b1;
    @(posedge clk); #1;
    chk("crank_enter", 32'(state), 32'd1);
    chk("crank_rpm0", rpmVal, 32'h0);
    next_tick; chk("crank_t1", rpmVal, 32'h20);
    next_tick; chk("crank_t2", rpmVal, 32'h40);
    next_tick; chk("crank_t3", rpmVal, 32'h60);
    chk("crank_t3_state", 32'(state), 32'd1);
    next_tick; chk("crank_t4", rpmVal, 32'h80);
    chk("run_enter", 32'(state), 32'd2);

    // Acceleration: 3*4*0x10 = 0xC0 per tick
    throttle = 4'd3;
    next_tick; chk("accel_1", rpmVal, 32'h140);
    next_tick; chk("accel_2", rpmVal, 32'h200);
    throttle = 4'd14; gearRatio = 8'd16;     // +0xE00
    next_tick; chk("accel_3", rpmVal, 32'h1000);

    // Upshift, then hold for two ticks despite full throttle
    throttle = 4'd15; shift = 2'b01;
    @(posedge clk); #1;
    chk("upshift_rpm", rpmVal, 32'h800);
    chk("upshift_state", 32'(state), 32'd3);
    shift = 2'b00;
    next_tick; chk("hold1_rpm", rpmVal, 32'h800);
    chk("hold1_state", 32'(state), 32'd3);
    next_tick; chk("hold2_rpm", rpmVal, 32'h800);
    chk("hold2_state", 32'(state), 32'd2);

    // shift=11 is not an event
    shift = 2'b11;
    @(posedge clk); #1;
    chk("shift11_state", 32'(state), 32'd2);
    chk("shift11_rpm", rpmVal, 32'h800);
    shift = 2'b00;

    // Saturation: 15*255*0x10 = 0xEF10 per tick
    gearRatio = 8'd255;
    exp_rpm = 32'h800;
    while (exp_rpm + 32'h0000EF10 < MAXV) begin
      next_tick;
      exp_rpm = exp_rpm + 32'h0000EF10;
    end
    chk("presat_rpm", rpmVal, exp_rpm);
    chk("presat_overrev", 32'(overrev), 32'd0);
    next_tick;
    chk("sat_rpm", rpmVal, MAXV);
    chk("sat_overrev", 32'(overrev), 32'd1);

    // Downshift at ceiling stays saturated
    shift = 2'b10;
    @(posedge clk); #1;
    chk("dnshift_rpm", rpmVal, MAXV);
    chk("dnshift_state", 32'(state), 32'd3);
    chk("dnshift_overrev", 32'(overrev), 32'd1);
    shift = 2'b00;

    // Asynchronous reset mid-SHIFTING, no clock edge
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rpm", rpmVal, 32'h0);
    chk("async_rst_state", 32'(state), 32'd0);
    chk("async_rst_overrev", 32'(overrev), 32'd0);

    // Restart to idle, then reach 0x100
    @(negedge clk);
    throttle = 4'd0; gearRatio = 8'd8; rst_n = 1'b1;
    repeat (4) next_tick;
    chk("restart_rpm", rpmVal, 32'h80);
    chk("restart_state", 32'(state), 32'd2);
    throttle = 4'd1;                          // +0x80
    next_tick; chk("pre_brake", rpmVal, 32'h100);

    // Brake overrides throttle, floors at idle
    throttle = 4'd15; brake = 1'b1;
    next_tick; chk("brake_1", rpmVal, 32'hC0);
    next_tick; chk("brake_2", rpmVal, 32'h80);
    next_tick; chk("brake_floor", rpmVal, 32'h80);

    // Ignition off: STOPPED, drag decay to zero
    ignition = 1'b0;
    @(posedge clk); #1;
    chk("stop_state", 32'(state), 32'd0);
    chk("stop_rpm", rpmVal, 32'h80);
    next_tick; chk("stop_decay1", rpmVal, 32'h7C);
    next_tick; chk("stop_decay2", rpmVal, 32'h78);
    repeat (30) next_tick;
    chk("stop_zero", rpmVal, 32'h0);
    next_tick; chk("stop_floor", rpmVal, 32'h0);
    chk("stop_state_end", 32'(state), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/engine_rpm_model.md
ENGINE_RPM_MODEL -- requirements
Module: engine_rpm_model

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000: clk cycles per update tick.
REQ-002 SHALL have parameter ACCEL_STEP, default 32'h10: rpm gain per throttle×ratio unit per tick.
REQ-003 SHALL have parameter DRAG_STEP, default 32'h4: coast decay per tick.
REQ-004 SHALL have parameter BRAKE_STEP, default 32'h40: braking decay per tick.
REQ-005 SHALL have parameter CRANK_STEP, default 32'h20, and CRANK_TICKS, default 4: crank ramp per tick, and crank length in ticks.
REQ-006 SHALL have parameter RPM_IDLE, default 32'h80, and RPM_MAX, default 32'h00FFFFFF: running floor and saturation ceiling.
REQ-007 SHALL have parameter HOLD_TICKS, default 2: clutch-hold duration in ticks after a shift.
REQ-008 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-009 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-010 SHALL have port ignition, input, 1 bit: engine on request.
REQ-011 SHALL have port throttle, input, 4 bits: pedal level, 0 to 15.
REQ-012 SHALL have port brake, input, 1 bit: brake pedal.
REQ-013 SHALL have port gearRatio, input, 8 bits: ratio from the transmission stage.
REQ-014 SHALL have port shift, input, 2 bits: 01 = upshift, 10 = downshift, 00 = none.
REQ-015 SHALL have port rpmVal, output, 32 bits: current rpm, fed to the transmission.
REQ-016 SHALL have port state, output, 2 bits: 00 STOPPED, 01 CRANK, 10 RUN, 11 SHIFTING.
REQ-017 SHALL have port overrev, output, 1 bit: high while rpmVal equals RPM_MAX.

Function
REQ-018 SHALL free-run a tick counter 0..TICK_DIV-1 and assert an internal tick in the cycle the count equals TICK_DIV-1.
REQ-019 SHALL, in STOPPED, decrement rpmVal by DRAG_STEP per tick, flooring at 0.
REQ-020 SHALL, in STOPPED, move to CRANK on the first cycle ignition is sampled high.
REQ-021 SHALL, in CRANK, add CRANK_STEP per tick.
REQ-022 SHALL, after CRANK_TICKS ticks in CRANK, force rpmVal to RPM_IDLE and enter RUN on that tick.
REQ-023 SHALL, in RUN per tick with brake=1, apply rpmVal = max(rpmVal-BRAKE_STEP, RPM_IDLE); brake SHALL override throttle.
REQ-024 SHALL, in RUN per tick with brake=0 and throttle≠0, apply rpmVal = min(rpmVal + throttle×gearRatio×ACCEL_STEP, RPM_MAX), computed in at least 48 bits so nothing wraps.
REQ-025 SHALL, in RUN per tick with brake=0 and throttle=0, apply rpmVal = max(rpmVal-DRAG_STEP, RPM_IDLE).
REQ-026 SHALL register shift every cycle and detect a shift event when the current sample ≠00 and the previous sample was 00; 11 SHALL be ignored.
REQ-027 SHALL, on a shift event in RUN, update rpmVal on the next rising edge and enter SHIFTING.
REQ-028 SHALL set rpmVal to max(rpmVal>>1, RPM_IDLE) for an upshift.
REQ-029 SHALL set rpmVal to min(rpmVal<<1, RPM_MAX) for a downshift.
REQ-030 SHALL, in SHIFTING, hold rpmVal constant, ignore throttle, brake and shift events, and return to RUN after HOLD_TICKS ticks.
REQ-031 SHALL ignore shift events in STOPPED and CRANK.
REQ-032 SHALL, when ignition is sampled low in CRANK, RUN or SHIFTING, enter STOPPED on the next edge; ignition-low SHALL win over a simultaneous shift event or tick.
REQ-033 SHALL let a tick and a shift event arriving in the same RUN cycle apply the shift only, not the tick update.
REQ-034 SHALL drive overrev combinationally from rpmVal == RPM_MAX.

Reset
REQ-035 SHALL, on rst_n low, immediately set rpmVal=0, state=STOPPED, overrev=0, tick counter=0, shift history=00 and hold/crank counters=0, regardless of clk.
REQ-036 SHALL, after rst_n rises, produce the first tick after TICK_DIV rising edges.
REQ-037 SHALL, on reset asserted mid-operation (any state), abandon the operation with no partial update on the next edge.

Verification (TICK_DIV=4, other parameters at defaults)
REQ-038 SHALL cover: reset, then ignition=1 -> state CRANK; rpmVal 0x20, 0x40, 0x60 on successive ticks, then 0x80 with state RUN on the 4th tick.
REQ-039 SHALL cover: RUN at rpmVal=0x80, throttle=3, gearRatio=4 -> 0x140 after one tick, 0x200 after two.
REQ-040 SHALL cover: RUN at rpmVal=0x1000, shift 00->01 -> rpmVal=0x800 and state SHIFTING on the next edge; rpmVal held for 2 ticks despite throttle=15, then state RUN.
REQ-041 SHALL cover: RUN at rpmVal=0x00FFFF00, throttle=15, gearRatio=25 -> rpmVal=0x00FFFFFF and overrev=1; a further downshift keeps 0x00FFFFFF.
REQ-042 SHALL cover: RUN at rpmVal=0x100, brake=1 and throttle=15 -> 0xC0, then 0x80, then held at 0x80; ignition=0 -> STOPPED, decaying by 0x4 per tick to 0.
REQ-043 SHALL cover: rst_n pulsed low mid-SHIFTING with no clk edge -> rpmVal=0 and state=STOPPED immediately.
